// File: rtl/y86_mem_stage_if.sv
// Bus between the execute/decode side and the Y86-64 memory stage:
// instruction operands in, read data plus debug view and error flag out.
interface y86_mem_stage_if;
  logic [3:0]  icode;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valE;
  logic [63:0] valP;
  logic [63:0] valM;
  logic [63:0] datamem;
  logic        dmem_error;

  modport master (
    output icode, valA, valB, valE, valP,
    input  valM, datamem, dmem_error
  );

  modport slave (
    input  icode, valA, valB, valE, valP,
    output valM, datamem, dmem_error
  );
endinterface

// File: rtl/y86_mem_stage.sv
// Y86-64 memory stage: word-indexed data memory with combinational reads,
// single-edge writes, and asynchronous clear of every word on reset.
module y86_mem_stage #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  y86_mem_stage_if.slave  mem_if
);

  localparam logic [3:0] IC_RMMOVQ = 4'h4;
  localparam logic [3:0] IC_MRMOVQ = 4'h5;
  localparam logic [3:0] IC_CALL   = 4'h8;
  localparam logic [3:0] IC_RET    = 4'h9;
  localparam logic [3:0] IC_PUSHQ  = 4'hA;
  localparam logic [3:0] IC_POPQ   = 4'hB;
  localparam logic [63:0] DEPTH_W  = 64'(DEPTH);

  logic [63:0]   mem_q [DEPTH];

  logic          is_rd_s;
  logic          is_wr_s;
  logic          ea_from_a_s;
  logic [63:0]   wdata_s;
  logic [63:0]   ea_s;
  logic          in_range_s;
  logic [AW-1:0] idx_s;
  logic [63:0]   rd_word_s;
  logic          mem_we_d;
  logic [63:0]   mem_wdata_d;

  // Classify the instruction: access direction, address source, store data.
  always_comb begin
    is_rd_s     = 1'b0;
    is_wr_s     = 1'b0;
    ea_from_a_s = 1'b0;
    wdata_s     = 64'd0;
    case (mem_if.icode)
      IC_RMMOVQ: begin
        is_wr_s = 1'b1;
        wdata_s = mem_if.valA;
      end
      IC_MRMOVQ: begin
        is_rd_s = 1'b1;
      end
      IC_CALL: begin
        is_wr_s = 1'b1;
        wdata_s = mem_if.valP;
      end
      IC_RET: begin
        is_rd_s     = 1'b1;
        ea_from_a_s = 1'b1;
      end
      IC_PUSHQ: begin
        is_wr_s = 1'b1;
        wdata_s = mem_if.valA;
      end
      IC_POPQ: begin
        is_rd_s     = 1'b1;
        ea_from_a_s = 1'b1;
      end
      default: begin
        is_rd_s     = 1'b0;
        is_wr_s     = 1'b0;
        ea_from_a_s = 1'b0;
        wdata_s     = 64'd0;
      end
    endcase
  end

  // Effective address, range check over the full 64 bits, and word lookup.
  always_comb begin
    if (ea_from_a_s) begin
      ea_s = mem_if.valA;
    end else begin
      ea_s = mem_if.valE;
    end
    in_range_s = (ea_s < DEPTH_W);
    idx_s      = ea_s[AW-1:0];
    rd_word_s  = mem_q[idx_s];
  end

  // Out-of-range stores are dropped here, so the array never sees them.
  always_comb begin
    mem_we_d    = is_wr_s & in_range_s;
    mem_wdata_d = wdata_s;
  end

  // Output muxing: out-of-range lookups read as zero instead of an aliased word.
  always_comb begin
    if (in_range_s) begin
      mem_if.datamem = rd_word_s;
    end else begin
      mem_if.datamem = 64'd0;
    end
    if (is_rd_s && in_range_s) begin
      mem_if.valM = rd_word_s;
    end else begin
      mem_if.valM = 64'd0;
    end
    mem_if.dmem_error = (is_rd_s | is_wr_s) & ~in_range_s;
  end

  // Data memory array: cleared asynchronously, written on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 64'd0;
      end
    end else if (mem_we_d) begin
      mem_q[idx_s] <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_y86_mem_stage.sv
// Directed-vector bench for y86_mem_stage: stimulus pushes hand-computed
// expectations into a scoreboard queue that a separate monitor drains.
module tb_y86_mem_stage;

  typedef struct {
    string       name;
    logic [63:0] valm;
    logic [63:0] dmem;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  y86_mem_stage_if bus ();

  exp_t sb_q[$];
  event sample_ev;
  int   checks;
  int   failures;

  y86_mem_stage #(.DEPTH(256), .AW(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mem_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares every queued expectation when the stimulus samples.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (bus.valM !== e.valm) begin
          failures++;
          $display("FAIL %s valM: got %h want %h", e.name, bus.valM, e.valm);
        end
        checks++;
        if (bus.datamem !== e.dmem) begin
          failures++;
          $display("FAIL %s datamem: got %h want %h", e.name, bus.datamem, e.dmem);
        end
        checks++;
        if (bus.dmem_error !== e.err) begin
          failures++;
          $display("FAIL %s dmem_error: got %b want %b", e.name, bus.dmem_error, e.err);
        end
      end
    end
  end

  task automatic drive(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] e, input logic [63:0] p);
    bus.icode = ic;
    bus.valA  = a;
    bus.valB  = b;
    bus.valE  = e;
    bus.valP  = p;
  endtask

  task automatic expect_now(input string name, input logic [63:0] vm,
                            input logic [63:0] dm, input logic err);
    exp_t x;
    #1;
    x.name = name;
    x.valm = vm;
    x.dmem = dm;
    x.err  = err;
    sb_q.push_back(x);
    -> sample_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(4'h0, 64'd0, 64'd0, 64'd0, 64'd0);
    #12;
    rst_n = 1'b1;
    tick();

    // Seed a word, then check asynchronous reset clears it without a clock.
    drive(4'h4, 64'hAA, 64'd0, 64'd0, 64'd0);
    tick();
    drive(4'h5, 64'd0, 64'd0, 64'd0, 64'd0);
    expect_now("seed_read", 64'hAA, 64'hAA, 1'b0);
    rst_n = 1'b0;
    expect_now("async_reset", 64'd0, 64'd0, 1'b0);
    // Stores are suppressed while reset is held across an edge.
    drive(4'h4, 64'h77, 64'd0, 64'd0, 64'd0);
    tick();
    rst_n = 1'b1;
    drive(4'h0, 64'd0, 64'd0, 64'd0, 64'd0);
    expect_now("write_in_reset", 64'd0, 64'd0, 1'b0);

    // rmmovq store, visible on datamem after the edge; valM stays 0.
    drive(4'h4, 64'd5, 64'd0, 64'd0, 64'd0);
    expect_now("rmmovq_pre", 64'd0, 64'd0, 1'b0);
    tick();
    expect_now("rmmovq_post", 64'd0, 64'd5, 1'b0);

    // mrmovq read, with valB noise that must be ignored.
    drive(4'h5, 64'd0, 64'hDEAD_BEEF, 64'd0, 64'd0);
    expect_now("mrmovq", 64'd5, 64'd5, 1'b0);
    tick();
    expect_now("mrmovq_hold", 64'd5, 64'd5, 1'b0);

    // call writes valP at valE; ret reads back via valA.
    drive(4'h8, 64'd0, 64'd0, 64'd3, 64'h40);
    tick();
    drive(4'h9, 64'd3, 64'd0, 64'd0, 64'd0);
    expect_now("ret", 64'h40, 64'h40, 1'b0);

    // pushq / popq pair, then a non-access icode viewing the same word.
    drive(4'hA, 64'h1234, 64'd0, 64'd10, 64'd0);
    tick();
    drive(4'hB, 64'd10, 64'd0, 64'd0, 64'd0);
    expect_now("popq", 64'h1234, 64'h1234, 1'b0);
    drive(4'h0, 64'd0, 64'd0, 64'd10, 64'd0);
    expect_now("nop_view", 64'd0, 64'h1234, 1'b0);

    // Out-of-range store: flagged, and the aliased word 300&255=44 untouched.
    drive(4'h4, 64'd7, 64'd0, 64'd300, 64'd0);
    expect_now("oor_store", 64'd0, 64'd0, 1'b1);
    tick();
    drive(4'h5, 64'd0, 64'd0, 64'd44, 64'd0);
    expect_now("alias_clean", 64'd0, 64'd0, 1'b0);
    drive(4'h5, 64'd0, 64'd0, 64'd300, 64'd0);
    expect_now("oor_load", 64'd0, 64'd0, 1'b1);
    drive(4'h0, 64'd0, 64'd0, 64'd300, 64'd0);
    expect_now("oor_noaccess", 64'd0, 64'd0, 1'b0);
    drive(4'hB, 64'd256, 64'd0, 64'd0, 64'd0);
    expect_now("popq_oor", 64'd0, 64'd0, 1'b1);
    drive(4'h9, 64'h1_0000_0000_0003, 64'd0, 64'd3, 64'd0);
    expect_now("ret_high_bits", 64'd0, 64'd0, 1'b1);
    drive(4'h5, 64'd0, 64'd0, 64'd0, 64'd0);
    expect_now("word0_intact", 64'd5, 64'd5, 1'b0);

    // Top word of the array.
    drive(4'hA, 64'hFFEE, 64'd0, 64'd255, 64'd0);
    tick();
    drive(4'h5, 64'd0, 64'd0, 64'd255, 64'd0);
    expect_now("top_word", 64'hFFEE, 64'hFFEE, 1'b0);

    // Overwrite then read next cycle; pushq at index 3 replaces call data.
    drive(4'hA, 64'h99, 64'd0, 64'd3, 64'd0);
    tick();
    drive(4'hB, 64'd3, 64'd0, 64'd0, 64'd0);
    expect_now("raw_overwrite", 64'h99, 64'h99, 1'b0);

    #5;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
